// File: rtl/sd_fsm.sv
// -----------------------------------------------------------------------------
// sd_fsm
// Moore sequence detector for the serial pattern 1-0-1-1 (first bit in time is
// the leading 1). Overlapping matches are allowed, so a completed match can
// reuse its trailing 1 as the leading 1 of the next pattern. The closest two
// pulses can be is three cycles, as in the stream 1011011.
//
// Ports
//   clock        : system clock, all state updates on the rising edge
//   reset        : synchronous active-high reset, returns the FSM to ZERO
//   sequence_in  : serial data bit, sampled on every rising edge
//   detector_out : high for one cycle while the FSM sits in the match state
// -----------------------------------------------------------------------------
module sd_fsm (
  input  logic clock,
  input  logic reset,
  input  logic sequence_in,
  output logic detector_out
);

  // Each state is named after the longest prefix of 1011 matched so far.
  typedef enum logic [2:0] {
    ZERO          = 3'd0,
    ONE           = 3'd1,
    ONEZERO       = 3'd2,
    ONEZEROONE    = 3'd3,
    ONEZEROONEONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_detect;

  // Next-state rules for the prefix-matching automaton. On a mismatch the
  // machine falls back to the longest suffix of the bits seen so far that is
  // still a prefix of 1011. Codes 5..7 cannot be reached from reset, but if the
  // register ever holds one of them the machine goes back to ZERO.
  always_comb begin
    w_nextState = ZERO;
    case (r_state)
      ZERO:          w_nextState = sequence_in ? ONE           : ZERO;
      ONE:           w_nextState = sequence_in ? ONE           : ONEZERO;
      ONEZERO:       w_nextState = sequence_in ? ONEZEROONE    : ZERO;
      ONEZEROONE:    w_nextState = sequence_in ? ONEZEROONEONE : ONEZERO;
      ONEZEROONEONE: w_nextState = sequence_in ? ONE           : ONEZERO;
      default:       w_nextState = ZERO;
    endcase
  end

  // The state register and the registered match flag update together. The
  // flag is loaded from the decode of the next state, so after every edge it
  // equals "current state is ONEZEROONEONE". It never depends combinationally
  // on sequence_in. Reset has priority and throws away any partial match.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ZERO;
      r_detect <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_detect <= (w_nextState == ONEZEROONEONE);
    end
  end

  assign detector_out = r_detect;

endmodule

// File: tb/tb_sd_fsm.sv
// -----------------------------------------------------------------------------
// tb_sd_fsm
// Bench for the 1011 sequence detector. The stimulus side drives the reset and
// data bits, and a pattern-window model predicts the detector output for each
// edge. Each prediction is pushed into a queue. A separate monitor pops one
// prediction after every rising edge and compares it with the DUT output.
// The directed scenarios come first, followed by a long random stream with
// occasional resets.
// -----------------------------------------------------------------------------
module tb_sd_fsm;

  logic clock;
  logic reset;
  logic sequence_in;
  logic detector_out;

  int checks = 0;
  int errors = 0;

  // Expected output for each issued edge, with a label for messages.
  bit    expQ[$];
  string nameQ[$];

  // Reference model: the last four bits received since the most recent reset.
  // A match means those four bits, oldest first, spell 1011.
  bit [3:0] history = 4'b0000;
  int       stepNo  = 0;

  sd_fsm dut (
    .clock       (clock),
    .reset       (reset),
    .sequence_in (sequence_in),
    .detector_out(detector_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one edge's worth of input on the falling edge, advance the model and
  // queue the value the output should show after the following rising edge.
  task automatic applyStimulus(input bit rst, input bit din, input string tag);
    bit expected;
    @(negedge clock);
    reset       = rst;
    sequence_in = din;
    if (rst) begin
      history  = 4'b0000;
      expected = 1'b0;
    end else begin
      history  = {history[2:0], din};
      expected = (history == 4'b1011);
    end
    stepNo++;
    expQ.push_back(expected);
    nameQ.push_back($sformatf("%s#%0d", tag, stepNo));
  endtask

  task automatic applyBits(input string bits, input string tag);
    for (int i = 0; i < bits.len(); i++)
      applyStimulus(1'b0, bits[i] == "1", tag);
  endtask

  task automatic checkOutput(input bit expected, input string name);
    checks++;
    if (detector_out !== expected) begin
      errors++;
      $display("[TB] FAIL %s: detector_out=%b expected=%b", name, detector_out, expected);
    end
  endtask

  // Monitor: sample #1 after each rising edge and check against the oldest
  // queued prediction.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front(), nameQ.pop_front());
    end
  end

  initial begin
    int waitCycles;
    reset       = 1'b1;
    sequence_in = 1'b1;

    // Reset edge with the data bit high, followed by idle zeros.
    applyStimulus(1'b1, 1'b1, "reset");
    applyBits("000", "idle");

    // Basic match, overlap, near-misses, recovery.
    applyBits("010110", "basic");
    applyStimulus(1'b1, 1'b0, "rst2");
    applyBits("1011011", "overlap");
    applyStimulus(1'b1, 1'b0, "rst3");
    applyBits("10011", "nearA");
    applyBits("1111", "nearB");
    applyStimulus(1'b1, 1'b0, "rst4");
    applyBits("11011", "recover");

    // A reset in the middle of a partial match must discard it.
    applyBits("0101", "mid");
    applyStimulus(1'b1, 1'b0, "midRst");
    applyBits("1", "afterRst");
    applyBits("0000", "flush");
    applyBits("1011", "postRst");

    // Random stream with sparse resets. The data is biased toward 1s so that
    // matches appear often.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 2)
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), "rndRst");
      else
        applyStimulus(1'b0, ($urandom_range(0, 99) < 60), "rnd");
    end

    // Let the monitor drain the queue, with a bound on how long it can take.
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clock);
      #2;
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
